// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one event counter among NUM_REQ requesters.
// Buffers events per requester, issues one inc per cycle, stops before wrap.
module counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PEND_W  = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               clr,
  output logic               inc,
  output logic [NUM_REQ-1:0] grant,
  output logic               count_resetn,
  output logic [NUM_REQ-1:0] drop,
  output logic [NUM_REQ-1:0] pend_full,
  output logic               sat
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [LW-1:0]     LAST0 = LW'(NUM_REQ - 1);

  logic [PEND_W-1:0] pend_q [NUM_REQ];
  logic [PEND_W-1:0] pend_d [NUM_REQ];
  logic [CNT_W-1:0]  mirror_q;
  logic [LW-1:0]     last_q;
  logic [LW-1:0]     sel;
  logic              any_el;
  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] drop_d;
  int                rr_idx;

  assign sat = (mirror_q == CMAX);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_full[i] = (pend_q[i] == PMAX);
    end
  end

  // Search starts one past the last owner; only registered pending counts.
  always_comb begin
    any_el = 1'b0;
    sel    = last_q;
    rr_idx = 0;
    gnt_d  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = int'(last_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!any_el && pend_q[LW'(rr_idx)] != '0) begin
        any_el = 1'b1;
        sel    = LW'(rr_idx);
      end
    end
    if (any_el && !sat) gnt_d[sel] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_d[i] = pend_q[i];
      drop_d[i] = 1'b0;
      if (req[i] && !gnt_d[i]) begin
        if (pend_q[i] == PMAX) drop_d[i] = 1'b1;
        else pend_d[i] = pend_q[i] + 1'b1;
      end else if (!req[i] && gnt_d[i]) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      inc          <= 1'b0;
      grant        <= '0;
      drop         <= '0;
      count_resetn <= 1'b0;
      mirror_q     <= '0;
      last_q       <= LAST0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      inc          <= |gnt_d;
      grant        <= gnt_d;
      drop         <= drop_d;
      count_resetn <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_q[i] <= pend_d[i];
      end
      if (|gnt_d) begin
        last_q   <= sel;
        mirror_q <= mirror_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: cycle model feeds a scoreboard queue,
// plus a behavioural shared counter for end-to-end count checks.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       clr;
  logic       inc;
  logic [3:0] grant;
  logic       count_resetn;
  logic [3:0] drop;
  logic [3:0] pend_full;
  logic       sat;

  counter_arbiter #(.NUM_REQ(4), .PEND_W(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .clr(clr),
    .inc(inc), .grant(grant), .count_resetn(count_resetn),
    .drop(drop), .pend_full(pend_full), .sat(sat)
  );

  always #5 clk = ~clk;

  logic [7:0] cnt = 8'd0;
  always @(posedge clk) begin
    if (count_resetn !== 1'b1) cnt <= 8'd0;
    else if (inc) cnt <= cnt + 8'd1;
  end

  typedef struct packed {
    logic       inc;
    logic [3:0] grant;
    logic       crn;
    logic [3:0] drop;
    logic [3:0] pf;
    logic       sat;
  } exp_t;

  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int m_pend[4];
  int m_mirror;
  int m_last;
  int g0, d0, pf0_seen;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic r, input logic c,
                                 input logic [3:0] rq);
    exp_t e;
    int   s;
    int   j;
    e = '0;
    if (r || c) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      m_mirror = 0;
      m_last   = 3;
    end else begin
      s = -1;
      if (m_mirror != 255) begin
        for (int k = 1; k <= 4; k++) begin
          j = (m_last + k) % 4;
          if (s < 0 && m_pend[j] > 0) s = j;
        end
      end
      e.crn = 1'b1;
      if (s >= 0) begin
        e.inc = 1'b1;
        e.grant[s] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (rq[i] && s != i) begin
          if (m_pend[i] == 7) e.drop[i] = 1'b1;
          else m_pend[i]++;
        end else if (!rq[i] && s == i) begin
          m_pend[i]--;
        end
      end
      if (s >= 0) begin
        m_last = s;
        m_mirror++;
      end
    end
    for (int i = 0; i < 4; i++) e.pf[i] = (m_pend[i] == 7);
    e.sat = (m_mirror == 255);
    return e;
  endfunction

  task automatic step(input logic r, input logic c, input logic [3:0] rq);
    exp_t e;
    reset = r;
    clr   = c;
    req   = rq;
    sbq.push_back(model(r, c, rq));
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("inc", int'(inc), int'(e.inc));
      chk("grant", int'(grant), int'(e.grant));
      chk("count_resetn", int'(count_resetn), int'(e.crn));
      chk("drop", int'(drop), int'(e.drop));
      chk("pend_full", int'(pend_full), int'(e.pf));
      chk("sat", int'(sat), int'(e.sat));
    end
    if (grant[0] === 1'b1) g0++;
    if (drop[0] === 1'b1) d0++;
    if (pend_full[0] === 1'b1) pf0_seen = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr   = 1'b0;
    req   = '0;

    // 1: reset and release
    repeat (3) step(1'b1, 1'b0, 4'b0000);
    chk("t1_inc", int'(inc), 0);
    chk("t1_crn", int'(count_resetn), 0);
    chk("t1_sat", int'(sat), 0);
    step(1'b0, 1'b0, 4'b0000);
    chk("t1_crn_rel", int'(count_resetn), 1);

    // 2: single event, two-cycle latency
    step(1'b0, 1'b0, 4'b0100);
    chk("t2_c1_inc", int'(inc), 0);
    step(1'b0, 1'b0, 4'b0000);
    chk("t2_c2_grant", int'(grant), 4);
    step(1'b0, 1'b0, 4'b0000);
    chk("t2_c3_inc", int'(inc), 0);
    chk("t2_cnt", int'(cnt), 1);

    // 3: all four at once after reset
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 4'b0000);
      chk("t3_order", int'(grant), 1 << k);
    end
    step(1'b0, 1'b0, 4'b0000);
    chk("t3_cnt", int'(cnt), 4);

    // 4: req[0] held while others are backed up
    step(1'b1, 1'b0, 4'b0000);
    repeat (6) step(1'b0, 1'b0, 4'b1110);
    g0 = 0; d0 = 0; pf0_seen = 0;
    repeat (10) step(1'b0, 1'b0, 4'b0001);
    repeat (30) step(1'b0, 1'b0, 4'b0000);
    chk("t4_pf_seen", pf0_seen, 1);
    chk("t4_inc_drop", g0 + d0, 10);
    chk("t4_drained", int'(inc), 0);

    // 5: saturation, no wrap
    step(1'b1, 1'b0, 4'b0000);
    g0 = 0; d0 = 0;
    repeat (270) step(1'b0, 1'b0, 4'b0001);
    chk("t5_sat", int'(sat), 1);
    chk("t5_grants", g0, 255);
    chk("t5_drops", d0, 8);
    chk("t5_pf", int'(pend_full[0]), 1);
    repeat (3) step(1'b0, 1'b0, 4'b1111);
    chk("t5_noinc", int'(inc), 0);
    chk("t5_cnt", int'(cnt), 255);

    // 6: clear mid-burst
    step(1'b1, 1'b0, 4'b0000);
    repeat (3) step(1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b1, 4'b1111);
    chk("t6_crn", int'(count_resetn), 0);
    chk("t6_inc", int'(inc), 0);
    chk("t6_pf", int'(pend_full), 0);
    chk("t6_sat", int'(sat), 0);
    step(1'b0, 1'b0, 4'b1111);
    chk("t6_cnt", int'(cnt), 0);
    step(1'b0, 1'b0, 4'b0000);
    chk("t6_first", int'(grant), 1);
    step(1'b0, 1'b0, 4'b0000);
    chk("t6_second", int'(grant), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
